// File: rtl/cache_fifo_wr_arb.sv
// cache_fifo_wr_arb: round-robin write arbiter in front of a sync FIFO.
// NUM_REQ requesters compete for one registered FIFO write port; a
// flush request drains the FIFO, then pulses fifo_soft_rst/flush_done.
// Optional build macro CACHE_FIFO_ARB_PRIO_EN: requester 0 gets fixed
// priority and the rotation covers requesters 1..NUM_REQ-1 only.
module cache_fifo_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 16,
    localparam int IDW       = $clog2(NUM_REQ),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_write,
    output logic [IDW+DATA_WIDTH-1:0]     fifo_write_data,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    input  logic [CW-1:0]                 fifo_data_num,
    output logic                          fifo_soft_rst,
    input  logic                          flush_req,
    output logic                          flush_done
);

    // Occupancy sum is widened so data_num + write can never wrap.
    localparam int SW = IDW + CW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

    state_t                state, state_nxt;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        win_idx;
    logic [IDW-1:0]        cand;
    logic                  found;
    logic                  grant;
    logic                  rr_upd;
    logic                  space_ok;
    logic [SW-1:0]         occ_next;
    logic [DATA_WIDTH-1:0] win_data;

    // Space check: one slot must remain after the in-flight write lands.
    always_comb begin
        occ_next = SW'(fifo_data_num) + SW'(fifo_write);
        space_ok = (occ_next < SW'(FIFO_DEPTH)) && !fifo_full;
    end

    // Winner search: scan upward from rr_ptr+1, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
`ifdef CACHE_FIFO_ARB_PRIO_EN
        if (req_valid[0]) begin
            found   = 1'b1;
            win_idx = '0;
        end
`endif
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDW'((32'(rr_ptr) + off) % NUM_REQ);
`ifdef CACHE_FIFO_ARB_PRIO_EN
            if (!found && req_valid[cand] && (cand != '0)) begin
`else
            if (!found && req_valid[cand]) begin
`endif
                found   = 1'b1;
                win_idx = cand;
            end
        end
        win_data = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the flush sequence.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (flush_req) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty && !fifo_write) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Grant outputs: blocked outside RUN, on flush entry, when full or in reset.
    always_comb begin
        grant     = rst_n && (state == RUN) && !flush_req && space_ok && found;
        req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
`ifdef CACHE_FIFO_ARB_PRIO_EN
        rr_upd    = grant && (win_idx != '0);
`else
        rr_upd    = grant;
`endif
    end

    // Registered FIFO write port, flush strobes and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= IDW'(NUM_REQ - 1);
            fifo_write      <= 1'b0;
            fifo_write_data <= '0;
            fifo_soft_rst   <= 1'b0;
            flush_done      <= 1'b0;
        end else begin
            fifo_write    <= grant;
            fifo_soft_rst <= (state == CLEAR);
            flush_done    <= (state == CLEAR);
            if (grant) begin
                fifo_write_data <= {win_idx, win_data};
            end
            if (state == CLEAR) begin
                rr_ptr <= IDW'(NUM_REQ - 1);
            end else if (rr_upd) begin
                rr_ptr <= win_idx;
            end
        end
    end

endmodule
